dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    typedef struct packed {
        logic              write;
        logic [1:0]        offset;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // Expand byte enables into a 32-bit lane mask.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    // Word and halfword accesses must be naturally aligned; other lane patterns never fault.
    function automatic logic misaligned(input logic [BE_W-1:0] be, input logic [1:0] offset);
        logic bad;
        case (be)
            4'b1111:          bad = (offset != 2'b00);
            4'b0011, 4'b1100: bad = offset[0];
            default:          bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-enable writes and a registered read port.
// The read port can overlay masked data (posted-write forwarding) or force zero.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic              zero,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic [DATA_W-1:0] ovl_mask,
    input  logic [DATA_W-1:0] ovl_data,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= (mem[idx] & ~lane_mask(be)) | (wdata & lane_mask(be));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= zero ? '0 : ((mem[idx] & ~ovl_mask) | (ovl_data & ovl_mask));
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: stalls the core for LAT wait cycles per access.
// Optional DMEM_WRITE_BUFFER_EN adds a one-entry posted write buffer.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    input  logic [3:0]  byteEn,
    output logic [31:0] readData,
    output logic        stall,
    output logic        addrErr
);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    req_t              req_q;
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] idx_in;
    logic              req, capture, access, access_mis;
    logic              post, hold;
    logic              unused_addr;

    logic              arr_en, arr_we, arr_zero;
    logic [ADDR_W-1:0] arr_idx;
    logic [DATA_W-1:0] arr_wdata, ovl_mask, ovl_data;
    logic [BE_W-1:0]   arr_be;

    assign req         = memRead | memWrite;
    assign idx_in      = addr[ADDR_W+1:2];
    assign unused_addr = ^addr[31:ADDR_W+2];
    assign access_mis  = misaligned(req_q.be, req_q.offset);

`ifdef DMEM_WRITE_BUFFER_EN
    logic              wb_valid, commit;
    logic [CNT_W-1:0]  wb_cnt;
    logic [ADDR_W-1:0] wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic [BE_W-1:0]   wb_be;

    assign post   = (state == IDLE) && memWrite && !wb_valid && !misaligned(byteEn, addr[1:0]);
    assign hold   = memWrite && wb_valid;
    assign commit = wb_valid && (wb_cnt == '0) && !access;

    // Posted write buffer; FSM accesses win the RAM port, commit waits a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_cnt   <= '0;
            wb_idx   <= '0;
            wb_data  <= '0;
            wb_be    <= '0;
        end else if (post) begin
            wb_valid <= 1'b1;
            wb_cnt   <= CNT_W'(LAT);
            wb_idx   <= idx_in;
            wb_data  <= writeData;
            wb_be    <= byteEn;
        end else if (commit) begin
            wb_valid <= 1'b0;
        end else if (wb_valid && wb_cnt != '0) begin
            wb_cnt <= wb_cnt - 1'b1;
        end
    end
`else
    assign post = 1'b0;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        capture    = 1'b0;
        access     = 1'b0;
        case (state)
            IDLE: begin
                if (post) begin
                    stall = 1'b0;
                end else if (hold) begin
                    stall = 1'b1;
                end else if (req) begin
                    stall      = 1'b1;
                    capture    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    access     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch and wait-state counter; write wins when both strobes are set.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            req_q   <= '0;
            req_idx <= '0;
            addrErr <= 1'b0;
        end else begin
            addrErr <= access && access_mis;
            if (capture) begin
                req_q   <= '{write: memWrite, offset: addr[1:0], wdata: writeData, be: byteEn};
                req_idx <= idx_in;
                cnt     <= CNT_W'(LAT);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        arr_en    = access & ~rst;
        arr_we    = req_q.write & ~access_mis;
        arr_zero  = access_mis;
        arr_idx   = req_idx;
        arr_wdata = req_q.wdata;
        arr_be    = req_q.be;
        ovl_mask  = '0;
        ovl_data  = '0;
`ifdef DMEM_WRITE_BUFFER_EN
        ovl_data = wb_data;
        if (wb_valid && wb_idx == req_idx) begin
            ovl_mask = lane_mask(wb_be);
        end
        if (commit) begin
            arr_en    = ~rst;
            arr_we    = 1'b1;
            arr_zero  = 1'b0;
            arr_idx   = wb_idx;
            arr_wdata = wb_data;
            arr_be    = wb_be;
        end
`endif
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .en       (arr_en),
        .we       (arr_we),
        .zero     (arr_zero),
        .idx      (arr_idx),
        .wdata    (arr_wdata),
        .be       (arr_be),
        .ovl_mask (ovl_mask),
        .ovl_data (ovl_data),
        .rdata    (readData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LAT=2 instance and one LAT=0 instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [31:0] addr_a, wd_a, addr_b, wd_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] rdata_a, rdata_b;
    logic        stall_a, stall_b, err_a, err_b;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_W(10), .LAT(2)) u_dut_a (
        .clk(clk), .rst(rst), .memRead(rd_a), .memWrite(wr_a), .addr(addr_a),
        .writeData(wd_a), .byteEn(be_a), .readData(rdata_a), .stall(stall_a), .addrErr(err_a)
    );

    dmem_responder #(.ADDR_W(10), .LAT(0)) u_dut_b (
        .clk(clk), .rst(rst), .memRead(rd_b), .memWrite(wr_b), .addr(addr_b),
        .writeData(wd_b), .byteEn(be_b), .readData(rdata_b), .stall(stall_b), .addrErr(err_b)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs_a[16];
    vec_t vecs_b[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit b, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (b) begin
            rd_b = rd; wr_b = wr; addr_b = a; wd_b = d; be_b = be;
        end else begin
            rd_a = rd; wr_a = wr; addr_a = a; wd_a = d; be_a = be;
        end
    endtask

    // Issue one access, hold it while stalled, sample results in the first unstalled cycle.
    task automatic run_access(input bit b, input vec_t v, input string tag);
        int          n;
        int          e_total;
        logic        st;
        logic        e_done;
        logic [31:0] rdv;
        @(negedge clk);
        drive(b, v.rd, v.wr, v.addr, v.wdata, v.be);
        #1;
        n       = 0;
        e_total = 0;
        st      = b ? stall_b : stall_a;
        while (st && n < 40) begin
            n++;
            e_total += int'(b ? err_b : err_a);
            @(negedge clk);
            #1;
            st = b ? stall_b : stall_a;
        end
        rdv    = b ? rdata_b : rdata_a;
        e_done = b ? err_b : err_a;
        e_total += int'(e_done);
        drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        e_total += int'(b ? err_b : err_a);
        check($sformatf("%s_stall_cycles", tag), 32'(n), 32'(v.exp_stall));
        check($sformatf("%s_rdata", tag), rdv, v.exp_rdata);
        check($sformatf("%s_err_done", tag), {31'h0, e_done}, {31'h0, v.exp_err});
        check($sformatf("%s_err_pulses", tag), 32'(e_total), {31'h0, v.exp_err});
    endtask

    initial begin
        vec_t v;
        vecs_a[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 4'b1111, 4, 32'h00000000, 1'b0};
        vecs_a[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4, 32'hDEADBEEF, 1'b0};
        vecs_a[2]  = '{1'b0, 1'b1, 32'h10,   32'h0000AB00, 4'b0010, 4, 32'hDEADBEEF, 1'b0};
        vecs_a[3]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4, 32'hDEADABEF, 1'b0};
        vecs_a[4]  = '{1'b1, 1'b0, 32'h13,   32'h0,        4'b1111, 4, 32'h00000000, 1'b1};
        vecs_a[5]  = '{1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4, 32'hDEADABEF, 1'b0};
        vecs_a[6]  = '{1'b1, 1'b1, 32'h20,   32'h12345678, 4'b1111, 4, 32'hDEADABEF, 1'b0};
        vecs_a[7]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'b1111, 4, 32'h12345678, 1'b0};
        vecs_a[8]  = '{1'b0, 1'b1, 32'h22,   32'hFFFFFFFF, 4'b1111, 4, 32'h00000000, 1'b1};
        vecs_a[9]  = '{1'b1, 1'b0, 32'h20,   32'h0,        4'b1111, 4, 32'h12345678, 1'b0};
        vecs_a[10] = '{1'b0, 1'b1, 32'h22,   32'hAAAA0000, 4'b1100, 4, 32'h12345678, 1'b0};
        vecs_a[11] = '{1'b1, 1'b0, 32'h20,   32'h0,        4'b1111, 4, 32'hAAAA5678, 1'b0};
        vecs_a[12] = '{1'b0, 1'b1, 32'h21,   32'h0000FFFF, 4'b0011, 4, 32'h00000000, 1'b1};
        vecs_a[13] = '{1'b1, 1'b0, 32'h1020, 32'h0,        4'b1111, 4, 32'hAAAA5678, 1'b0};
        vecs_a[14] = '{1'b0, 1'b1, 32'h13,   32'h00000011, 4'b0001, 4, 32'hAAAA5678, 1'b0};
        vecs_a[15] = '{1'b1, 1'b0, 32'h10,   32'h0,        4'b1111, 4, 32'hDEADAB11, 1'b0};

        vecs_b[0]  = '{1'b0, 1'b1, 32'h0,    32'h5A5A5A5A, 4'b1111, 2, 32'h00000000, 1'b0};
        vecs_b[1]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        4'b1111, 2, 32'h5A5A5A5A, 1'b0};
        vecs_b[2]  = '{1'b1, 1'b0, 32'h2,    32'h0,        4'b1111, 2, 32'h00000000, 1'b1};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall_a", {31'h0, stall_a}, 32'h0);
        check("reset_rdata_a", rdata_a, 32'h0);
        check("reset_err_a",   {31'h0, err_a}, 32'h0);
        check("reset_stall_b", {31'h0, stall_b}, 32'h0);
        check("reset_rdata_b", rdata_b, 32'h0);
        check("reset_err_b",   {31'h0, err_b}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_access(1'b0, vecs_a[i], $sformatf("lat2_v%0d", i));
        end

        // Establish a known zero at 0x30, then reset in the last wait cycle of a write there.
        v = '{1'b0, 1'b1, 32'h30, 32'h00000000, 4'b1111, 4, 32'hDEADAB11, 1'b0};
        run_access(1'b0, v, "prep_0x30");
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111);
        #1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        check("midreset_stall", {31'h0, stall_a}, 32'h0);
        check("midreset_rdata", rdata_a, 32'h0);
        check("midreset_err",   {31'h0, err_a}, 32'h0);
        rst = 1'b0;
        v = '{1'b1, 1'b0, 32'h30, 32'h0, 4'b1111, 4, 32'h00000000, 1'b0};
        run_access(1'b0, v, "after_reset_read_0x30");

        for (int i = 0; i < 3; i++) begin
            run_access(1'b1, vecs_b[i], $sformatf("lat0_v%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
